proc_trace_checker: RTL

- Synthesizable, parametrised trace checker for processor test harnesses; it performs in hardware the expected-trace comparison that the task-based benches do procedurally.
- Sits beside the processor under test and snoops its trace_val / trace_addr / trace_data outputs.
- Compares each committed trace record against an expected-record FIFO loaded by the bench or a ROM sequencer.
- Reports pass/fail, error cause, first-failure capture and match count; also usable on FPGA with LEDs/UART.

---
 rtl/proc_trace_checker_pkg.sv | 27 ++
 rtl/proc_trace_checker_if.sv | 28 ++
 rtl/proc_trace_checker_trace_fifo.sv | 54 +++++
 rtl/proc_trace_checker.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/proc_trace_checker_pkg.sv
// Shared types for the processor trace checker: FSM states, error causes and
// the layout of one expected-trace record.
package proc_trace_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISMATCH   = 2'd1,
    ERR_UNEXPECTED = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_code_t;

  // A record is stored flat in the FIFO as {last, chk, addr, data}, with data
  // in the least significant bits. The widths depend on the checker
  // parameters, so the record is built by concatenation rather than as a
  // fixed packed struct; this helper gives the resulting width.
  function automatic int rec_width(input int addr_w, input int data_w);
    return addr_w + data_w + 2;
  endfunction

endpackage

// File: rtl/proc_trace_checker_if.sv
// Expected-record load channel and processor trace snoop channel.
// master: bench / ROM sequencer side; slave: the checker.
interface proc_trace_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              exp_val;
  logic              exp_rdy;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              exp_chk;
  logic              exp_last;
  logic              trace_val;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;

  modport master (
    output exp_val, exp_addr, exp_data, exp_chk, exp_last,
    output trace_val, trace_addr, trace_data,
    input  exp_rdy
  );

  modport slave (
    input  exp_val, exp_addr, exp_data, exp_chk, exp_last,
    input  trace_val, trace_addr, trace_data,
    output exp_rdy
  );
endinterface

// File: rtl/proc_trace_checker_trace_fifo.sv
// Synchronous FIFO holding expected trace records. Power-of-two depth so the
// pointers wrap naturally; storage is not reset, only pointers and count.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Record storage write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/proc_trace_checker.sv
// Hardware trace checker: compares each committed processor trace record
// against the head of an expected-record FIFO and reports pass/fail, the
// failure cause, a first-failure capture and the running match count.
module proc_trace_checker
  import proc_trace_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  proc_trace_checker_if.slave    bus,
  output logic                   busy,
  output logic                   pass,
  output logic                   fail,
  output logic [1:0]             err_code,
  output logic [CNT_W-1:0]       err_index,
  output logic [ADDR_W-1:0]      err_addr,
  output logic [DATA_W-1:0]      err_data,
  output logic [CNT_W-1:0]       match_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int REC_W = rec_width(ADDR_W, DATA_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  // Match counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  err_code_t         err_q, cap_code;
  logic [TMO_W-1:0]  tmo_q;
  logic [CNT_W-1:0]  match_q;

  logic              full, empty, push, pop, exp_rdy_w, terminal, hit;
  logic              cnt_inc, tmo_clr, tmo_inc, cap, cap_trace;
  logic [REC_W-1:0]  push_rec, head_rec;
  logic              head_last, head_chk;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign push_rec = {bus.exp_last, bus.exp_chk, bus.exp_addr, bus.exp_data};
  assign {head_last, head_chk, head_addr, head_data} = head_rec;

  // PASS/FAIL freeze the FIFO: no loads accepted once the verdict is in.
  assign terminal    = (state_q == PASS) || (state_q == FAIL);
  assign exp_rdy_w   = !full && !terminal;
  assign bus.exp_rdy = exp_rdy_w;
  assign push        = bus.exp_val && exp_rdy_w;

  assign hit = (bus.trace_addr == head_addr) &&
               (!head_chk || (bus.trace_data == head_data));

  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head_rec),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Checker FSM: next state plus pop / counter / capture strobes.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    cnt_inc   = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    cap       = 1'b0;
    cap_trace = 1'b0;
    cap_code  = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          tmo_clr = 1'b1;
        end
      end
      RUN: begin
        if (bus.trace_val) begin
          if (empty) begin
            // A push landing this same cycle is not visible yet.
            state_d   = FAIL;
            cap       = 1'b1;
            cap_trace = 1'b1;
            cap_code  = ERR_UNEXPECTED;
          end else if (hit) begin
            pop     = 1'b1;
            cnt_inc = 1'b1;
            tmo_clr = 1'b1;
            if (head_last) state_d = PASS;
          end else begin
            state_d   = FAIL;
            cap       = 1'b1;
            cap_trace = 1'b1;
            cap_code  = ERR_MISMATCH;
          end
        end else if (!empty) begin
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d  = FAIL;
            cap      = 1'b1;
            cap_code = ERR_TIMEOUT;
          end else begin
            tmo_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Match/timeout counters and first-failure capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q   <= '0;
      tmo_q     <= '0;
      err_q     <= ERR_NONE;
      err_index <= '0;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      if (cnt_inc) match_q <= sat_inc(match_q);
      if (tmo_clr)      tmo_q <= '0;
      else if (tmo_inc) tmo_q <= tmo_q + 1'b1;
      if (cap) begin
        err_q     <= cap_code;
        err_index <= match_q;
        err_addr  <= cap_trace ? bus.trace_addr : '0;
        err_data  <= cap_trace ? bus.trace_data : '0;
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign pass      = (state_q == PASS);
  assign fail      = (state_q == FAIL);
  assign err_code  = err_q;
  assign match_cnt = match_q;
endmodule
